// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp,
// datapath select codes and the main-control state enum.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluOpAdd   = 3'b000;
    localparam logic [2:0] AluOpSub   = 3'b001;
    localparam logic [2:0] AluOpRtype = 3'b010;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StBranch,
        StAddiEx,
        StAddiWb,
        StJump
    } state_e;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
               (op == OpBeq) || (op == OpAddi) || (op == OpJ);
    endfunction

endpackage

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// combinational output decode with a memory-ready stall handshake.
module mc_main_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e state_q, state_d;

    // The branch decision (PCWriteCond & zero) is made in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StRExec:  state_d = StRWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StRWb, StBranch, StAddiWb, StJump: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SrcBReg;
        PCSource    = PcSrcAlu;
        ALUOp       = AluOpAdd;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SrcBFour;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: begin
                ALUSrcB = SrcBImmSh2;
                if (!op_legal(opcode)) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            StMemAdr, StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            StRExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = AluOpRtype;
            end
            StRWb: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = AluOpSub;
                PCWriteCond = 1'b1;
                PCSource    = PcSrcAluOut;
                instr_done  = 1'b1;
            end
            StAddiWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StJump: begin
                PCWrite    = 1'b1;
                PCSource   = PcSrcJump;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset pins the FETCH selects and suppresses every write and pulse.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b1;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SrcBFour;
            PCSource    = PcSrcAlu;
            ALUOp       = AluOpAdd;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-cycle expected control words are
// queued as stimulus is driven and popped/compared once outputs settle.
module tb_mc_main_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;

    mc_main_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //  ALUSrcA,ALUSrcB,PCSource,ALUOp,instr_done,illegal_op}
    logic [18:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal_op};

    logic [18:0] exp_q[$];
    string       tag_q[$];
    int          nvec = 0;
    int          nmis = 0;

    function automatic logic [18:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic m2r, input logic rdst, input logic rw,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] pcsrc, input logic [2:0] aluop,
                                       input logic done, input logic ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcsrc, aluop,
                done, ill};
    endfunction

    // Expected control words, one per state, written out from the state table.
    logic [18:0] e_rst, e_fetch_go, e_fetch_wait, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb;
    logic [18:0] e_mwr_wait, e_mwr_go, e_rexec, e_rwb, e_br, e_aex, e_awb, e_jmp;

    task automatic check_out();
        logic [18:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        nvec++;
        assert (obs === e) else begin
            nmis++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    task automatic step(input string t, input logic rst_v, input logic [5:0] op,
                        input logic z, input logic mr, input logic [18:0] e);
        @(negedge clk);
        reset     = rst_v;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(t);
        #1;
        check_out();
    endtask

    initial begin
        e_rst        = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0);
        e_fetch_go   = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0);
        e_fetch_wait = e_rst;
        e_dec        = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0, 0);
        e_dec_ill    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 1, 1);
        e_madr       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0, 0);
        e_mrd        = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
        e_mwb        = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        e_mwr_wait   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
        e_mwr_go     = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        e_rexec      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0, 0);
        e_rwb        = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        e_br         = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 1, 0);
        e_aex        = e_madr;
        e_awb        = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        e_jmp        = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 1, 0);

        // Reset held three cycles with mem_ready high.
        for (int i = 0; i < 3; i++) step("reset_hold", 1, OpRtype, 0, 1, e_rst);

        // R-type, 4 cycles.
        step("r_fetch",  0, OpRtype, 0, 1, e_fetch_go);
        step("r_decode", 0, OpRtype, 0, 1, e_dec);
        step("r_exec",   0, OpRtype, 0, 1, e_rexec);
        step("r_wb",     0, OpRtype, 0, 1, e_rwb);

        // lw with two memory wait cycles in MEM_RD: 7 cycles.
        step("lw_fetch",  0, OpLw, 0, 1, e_fetch_go);
        step("lw_decode", 0, OpLw, 0, 1, e_dec);
        step("lw_adr",    0, OpLw, 0, 1, e_madr);
        step("lw_rd_w0",  0, OpLw, 0, 0, e_mrd);
        step("lw_rd_w1",  0, OpLw, 0, 0, e_mrd);
        step("lw_rd_go",  0, OpLw, 0, 1, e_mrd);
        step("lw_wb",     0, OpLw, 0, 1, e_mwb);

        // beq taken then not taken: 3 cycles each.
        step("beq1_fetch",  0, OpBeq, 1, 1, e_fetch_go);
        step("beq1_decode", 0, OpBeq, 1, 1, e_dec);
        step("beq1_branch", 0, OpBeq, 1, 1, e_br);
        step("beq0_fetch",  0, OpBeq, 0, 1, e_fetch_go);
        step("beq0_decode", 0, OpBeq, 0, 1, e_dec);
        step("beq0_branch", 0, OpBeq, 0, 1, e_br);

        // addi 4 cycles, j 3 cycles.
        step("addi_fetch",  0, OpAddi, 0, 1, e_fetch_go);
        step("addi_decode", 0, OpAddi, 0, 1, e_dec);
        step("addi_ex",     0, OpAddi, 0, 1, e_aex);
        step("addi_wb",     0, OpAddi, 0, 1, e_awb);
        step("j_fetch",     0, OpJ,    0, 1, e_fetch_go);
        step("j_decode",    0, OpJ,    0, 1, e_dec);
        step("j_jump",      0, OpJ,    0, 1, e_jmp);

        // Illegal opcode: pulse in DECODE, then straight back to FETCH.
        step("ill_fetch",   0, 6'b111111, 0, 1, e_fetch_go);
        step("ill_decode",  0, 6'b111111, 0, 1, e_dec_ill);

        // sw with a fetch stall, MEM_WR waits, then reset while in MEM_WR.
        step("sw_fetch_wait", 0, OpSw, 0, 0, e_fetch_wait);
        step("sw_fetch",      0, OpSw, 0, 1, e_fetch_go);
        step("sw_decode",     0, OpSw, 0, 1, e_dec);
        step("sw_adr",        0, OpSw, 0, 1, e_madr);
        step("sw_wr_w0",      0, OpSw, 0, 0, e_mwr_wait);
        step("sw_wr_w1",      0, OpSw, 0, 0, e_mwr_wait);
        step("sw_wr_reset",   1, OpSw, 0, 1, e_rst);
        nvec++;
        assert (dut.state_q === StFetch) else begin
            nmis++;
            $error("FAIL sw_reset_state: observed %0d expected %0d", dut.state_q, StFetch);
        end
        step("post_rst_fetch", 0, OpSw, 0, 1, e_fetch_go);

        // Full sw completing on the first MEM_WR cycle: 4 cycles, then FETCH.
        step("sw2_decode", 0, OpSw, 0, 1, e_dec);
        step("sw2_adr",    0, OpSw, 0, 1, e_madr);
        step("sw2_wr_go",  0, OpSw, 0, 1, e_mwr_go);
        step("sw2_fetch",  0, OpRtype, 0, 1, e_fetch_go);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
